gen_origin_axis_a2: RTL and testbench

Stream generator that expands one command (start value, beat count) into an AXI-Stream frame of consecutive values. It consumes commands through a simple enable/ready handshake and emits one frame per command on a master AXI-Stream port. Its typical use is as the core of run-length decompression: each (address, length) pair becomes a run of incrementing addresses.

---
 rtl/gen_origin_axis_a2.sv | 114 +++++++++++
 tb/tb_gen_origin_axis_a2.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gen_origin_axis_a2.sv
// gen_origin_axis_a2: expands one (start, length) command into an AXI-Stream frame of
// consecutive values (start + i in RANGE mode, i in ORIGIN mode).
module gen_origin_axis_a2 #(
  parameter string       MODE  = "RANGE",
  parameter int unsigned DSIZE = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     enable,
  output logic                     ready,
  input  logic [31:0]              length,
  input  logic [31:0]              start,
  output logic [DSIZE-1:0]         axis_tdata,
  output logic                     axis_tvalid,
  input  logic                     axis_tready,
  output logic                     axis_tlast,
  output logic [(DSIZE+7)/8-1:0]   axis_tkeep
);

  localparam bit IsRange = (MODE == "RANGE");

  // Reject unsupported configurations at elaboration.
  if ((MODE != "RANGE") && (MODE != "ORIGIN")) begin : g_bad_mode
    $error("gen_origin_axis_a2: MODE must be \"RANGE\" or \"ORIGIN\"");
  end
  if ((DSIZE < 1) || (DSIZE > 32)) begin : g_bad_dsize
    $error("gen_origin_axis_a2: DSIZE must be in 1..32");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [31:0]        start_q, start_d;
  logic [31:0]        length_q, length_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               tvalid_q, tvalid_d;
  logic [DSIZE-1:0]   tdata_q, tdata_d;
  logic               tlast_q, tlast_d;
  logic [31:0]        beat_val;

  // Next-state: command capture, beat counting and registered output values.
  // Outputs are derived from the next-state values so they only move on an accepted beat.
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    length_d = length_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          start_d  = start;
          length_d = length;
          cnt_d    = 32'd0;
          state_d  = (length != 32'd0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (axis_tready) begin
          if (tlast_q) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    beat_val = IsRange ? (start_d + cnt_d) : cnt_d;
    tvalid_d = (state_d == StRun);
    tdata_d  = beat_val[DSIZE-1:0];
    tlast_d  = (state_d == StRun) && (cnt_d == (length_d - 32'd1));
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      start_q  <= 32'd0;
      length_q <= 32'd0;
      cnt_q    <= 32'd0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      length_q <= length_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
    end
  end

  // Upper bits of the beat value are dropped by truncation to DSIZE.
  logic unused_beat_val;
  assign unused_beat_val = ^beat_val;

  // Command-consumed pulse: last beat accepted, or a zero-length command.
  assign ready = ((state_q == StRun) && axis_tready && tlast_q) || (state_q == StDone);

  assign axis_tvalid = tvalid_q;
  assign axis_tdata  = tdata_q;
  assign axis_tlast  = tlast_q;
  assign axis_tkeep  = '1;

endmodule

// File: tb/tb_gen_origin_axis_a2.sv
// Bench for gen_origin_axis_a2: a RANGE and an ORIGIN instance share the command and
// tready stimulus; each has its own scoreboard of expected {tlast, tdata} beats.
module tb_gen_origin_axis_a2;

  logic        clk = 1'b0;
  logic        aresetn, enable, tready;
  logic [31:0] start, length;

  logic        r_ready, r_tvalid, r_tlast;
  logic [7:0]  r_tdata;
  logic [0:0]  r_tkeep;
  logic        o_ready, o_tvalid, o_tlast;
  logic [7:0]  o_tdata;
  logic [0:0]  o_tkeep;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_cnt_r = 0;
  int rdy_cnt_o = 0;

  logic [8:0] qr[$];
  logic [8:0] qo[$];
  bit         stall_r = 0, stall_o = 0;
  logic [8:0] hold_r, hold_o;

  always #5 clk = ~clk;

  gen_origin_axis_a2 #(.MODE("RANGE"), .DSIZE(8)) u_range (
    .aclk(clk), .aresetn(aresetn), .enable(enable), .ready(r_ready),
    .length(length), .start(start), .axis_tdata(r_tdata), .axis_tvalid(r_tvalid),
    .axis_tready(tready), .axis_tlast(r_tlast), .axis_tkeep(r_tkeep)
  );

  gen_origin_axis_a2 #(.MODE("ORIGIN"), .DSIZE(8)) u_origin (
    .aclk(clk), .aresetn(aresetn), .enable(enable), .ready(o_ready),
    .length(length), .start(start), .axis_tdata(o_tdata), .axis_tvalid(o_tvalid),
    .axis_tready(tready), .axis_tlast(o_tlast), .axis_tkeep(o_tkeep)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected beats for one command on both instances.
  task automatic push_cmd(input logic [31:0] s, input logic [31:0] l);
    logic [31:0] v;
    logic        lst;
    for (int unsigned i = 0; i < l; i++) begin
      lst = (i == l - 1);
      v = s + i;
      qr.push_back({lst, v[7:0]});
      v = i;
      qo.push_back({lst, v[7:0]});
    end
  endtask

  // Drive one command (entered at the start of an idle cycle) and wait for ready.
  // With use_pat, tready follows pat[0], pat[1], ... from the first beat cycle on.
  task automatic run_cmd(input logic [31:0] s, input logic [31:0] l, input bit keep_en,
                         input logic [7:0] pat, input bit use_pat);
    int k;
    bit done;
    enable = 1'b1;
    start  = s;
    length = l;
    tready = 1'b1;
    push_cmd(s, l);
    k = 0;
    done = 0;
    while (!done && k < 64) begin
      @(negedge clk);
      if (k == 0) check("idle_before_frame", r_tvalid, 0);
      if (r_ready) begin
        done = 1;
        check("ready_sync_origin", o_ready, 1);
        if (!use_pat) check("ready_latency", k, (l == 0) ? 1 : l);
      end else begin
        @(posedge clk);
        #1;
        k++;
        tready = (!use_pat || k > 8) ? 1'b1 : pat[k-1];
      end
    end
    check("ready_seen", done, 1);
    @(posedge clk);
    #1;
    tready = 1'b1;
    if (!keep_en) enable = 1'b0;
  endtask

  task automatic check_pulses(input string tag, input int base_r, input int base_o,
                              input int exp);
    @(posedge clk);
    #1;
    check({tag, "_range"}, rdy_cnt_r - base_r, exp);
    check({tag, "_origin"}, rdy_cnt_o - base_o, exp);
  endtask

  // RANGE instance monitor: hold-stability, keep, scoreboard pop, ready with last.
  always @(negedge clk) begin
    logic [8:0] e;
    if (stall_r) begin
      check("hold_valid_range", r_tvalid, 1);
      check("hold_beat_range", {r_tlast, r_tdata}, hold_r);
    end
    if (r_tvalid) check("keep_range", r_tkeep, 1);
    if (r_tvalid && tready) begin
      check("beat_expected_range", qr.size() > 0, 1);
      if (qr.size() > 0) begin
        e = qr.pop_front();
        check("beat_range", {r_tlast, r_tdata}, e);
      end
      if (r_tlast) check("ready_with_last_range", r_ready, 1);
    end
    if (r_ready) rdy_cnt_r++;
    stall_r = r_tvalid && !tready;
    hold_r  = {r_tlast, r_tdata};
  end

  // ORIGIN instance monitor.
  always @(negedge clk) begin
    logic [8:0] e;
    if (stall_o) begin
      check("hold_valid_origin", o_tvalid, 1);
      check("hold_beat_origin", {o_tlast, o_tdata}, hold_o);
    end
    if (o_tvalid) check("keep_origin", o_tkeep, 1);
    if (o_tvalid && tready) begin
      check("beat_expected_origin", qo.size() > 0, 1);
      if (qo.size() > 0) begin
        e = qo.pop_front();
        check("beat_origin", {o_tlast, o_tdata}, e);
      end
      if (o_tlast) check("ready_with_last_origin", o_ready, 1);
    end
    if (o_ready) rdy_cnt_o++;
    stall_o = o_tvalid && !tready;
    hold_o  = {o_tlast, o_tdata};
  end

  initial begin
    int br, bo;
    bit done;
    aresetn = 1'b0;
    enable  = 1'b0;
    tready  = 1'b1;
    start   = 32'd0;
    length  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", r_tvalid, 0);
    check("rst_tlast", r_tlast, 0);
    check("rst_tdata", r_tdata, 0);
    check("rst_ready", r_ready, 0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame.
    br = rdy_cnt_r; bo = rdy_cnt_o;
    run_cmd(32'h10, 32'd4, 1'b0, 8'h00, 1'b0);
    check_pulses("pulses_basic", br, bo, 1);

    // Back-pressure: tready 1,0,0,1,0,1.
    br = rdy_cnt_r; bo = rdy_cnt_o;
    run_cmd(32'd5, 32'd3, 1'b0, 8'b0010_1001, 1'b1);
    check_pulses("pulses_bp", br, bo, 1);

    // Wrap modulo 2^8.
    br = rdy_cnt_r; bo = rdy_cnt_o;
    run_cmd(32'hFE, 32'd4, 1'b0, 8'h00, 1'b0);
    check_pulses("pulses_wrap", br, bo, 1);

    // Back-to-back with enable held high.
    br = rdy_cnt_r; bo = rdy_cnt_o;
    run_cmd(32'h0, 32'd1, 1'b1, 8'h00, 1'b0);
    run_cmd(32'h80, 32'd2, 1'b0, 8'h00, 1'b0);
    check_pulses("pulses_b2b", br, bo, 2);

    // start ignored in ORIGIN mode, then a zero-length command.
    br = rdy_cnt_r; bo = rdy_cnt_o;
    run_cmd(32'h55, 32'd3, 1'b0, 8'h00, 1'b0);
    run_cmd(32'h12, 32'd0, 1'b0, 8'h00, 1'b0);
    check_pulses("pulses_origin_zero", br, bo, 2);

    // Reset mid-frame after the second beat; frame restarts from start.
    br = rdy_cnt_r; bo = rdy_cnt_o;
    enable = 1'b1;
    start  = 32'h20;
    length = 32'd5;
    push_cmd(32'h20, 32'd5);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_tvalid_range", r_tvalid, 0);
    check("midrst_tvalid_origin", o_tvalid, 0);
    check("midrst_ready", r_ready, 0);
    check("midrst_no_pulse", rdy_cnt_r - br, 0);
    qr.delete();
    qo.delete();
    push_cmd(32'h20, 32'd5);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (r_ready) done = 1;
    end
    check("midrst_restart_ready", done, 1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    check_pulses("pulses_midrst", br, bo, 1);

    repeat (3) @(posedge clk);
    check("queue_empty_range", qr.size(), 0);
    check("queue_empty_origin", qo.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
